// File: rtl/noc_endpoint_ni.sv
// NoC endpoint network interface: credit-controlled injection with per-VC packet
// framing checks, and per-VC ejection FIFOs drained round-robin with credit return.
module noc_endpoint_ni #(
    parameter int V    = 4,
    parameter int B    = 4,
    parameter int Fpay = 32,
    localparam int Fw  = 2 + V + Fpay,
    localparam int Vw  = (V > 1) ? $clog2(V) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic            tx_hdr,
    input  logic            tx_tail,
    input  logic [Vw-1:0]   tx_vc,
    input  logic [Fpay-1:0] tx_data,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    input  logic [Fw-1:0]   flit_in,
    input  logic            flit_in_wr,
    output logic [V-1:0]    credit_out,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            rx_hdr,
    output logic            rx_tail,
    output logic [Vw-1:0]   rx_vc,
    output logic [Fpay-1:0] rx_data,
    output logic [2:0]      err
);

    localparam int CW = $clog2(B + 1);
    localparam int PW = (B > 1) ? $clog2(B) : 1;
    localparam int EW = Fpay + 2;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(B - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [Vw-1:0] vc_inc(input logic [Vw-1:0] v);
        return (v == Vw'(V - 1)) ? '0 : v + Vw'(1);
    endfunction

    // ---------------- state ----------------
    logic [CW-1:0]   credit_q [V];
    logic [CW-1:0]   credit_d [V];
    pkt_state_e      pkt_q    [V];
    pkt_state_e      pkt_d    [V];
    logic [Fw-1:0]   flit_out_q;
    logic            flit_out_wr_q;
    logic [V-1:0]    credit_out_q;
    logic [V-1:0]    credit_out_d;
    logic [2:0]      err_q;
    logic            err_tx_d;
    logic            err_cr_d;
    logic            err_rx_d;

    logic [EW-1:0]   mem_q    [V][B];
    logic [PW-1:0]   rd_ptr_q [V];
    logic [PW-1:0]   rd_ptr_d [V];
    logic [PW-1:0]   wr_ptr_q [V];
    logic [PW-1:0]   wr_ptr_d [V];
    logic [CW-1:0]   cnt_q    [V];
    logic [CW-1:0]   cnt_d    [V];
    logic [Vw-1:0]   rr_q;
    logic [Vw-1:0]   rr_d;
    logic            lock_q;
    logic            lock_d;
    logic [Vw-1:0]   lock_vc_q;
    logic [Vw-1:0]   lock_vc_d;

    // ---------------- injection ----------------
    logic [V-1:0]    tx_sel;
    logic [V-1:0]    has_credit;
    logic            accept;
    logic [V-1:0]    acc_vec;

    always_comb begin
        tx_sel     = '0;
        has_credit = '0;
        for (int v = 0; v < V; v++) begin
            tx_sel[v]     = (tx_vc == Vw'(v));
            has_credit[v] = (credit_q[v] != '0);
        end
    end

    assign tx_ready = |(tx_sel & has_credit);
    assign accept   = tx_valid & tx_ready;
    assign acc_vec  = {V{accept}} & tx_sel;

    always_comb begin
        err_tx_d = err_q[0];
        err_cr_d = err_q[1];
        for (int v = 0; v < V; v++) begin
            credit_d[v] = credit_q[v];
            pkt_d[v]    = pkt_q[v];
            // A credit and an accept in the same cycle cancel out.
            if (credit_in[v] && !acc_vec[v]) begin
                if (credit_q[v] == CW'(B))
                    err_cr_d = 1'b1;
                else
                    credit_d[v] = credit_q[v] + CW'(1);
            end else if (acc_vec[v] && !credit_in[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end
            if (acc_vec[v]) begin
                if (pkt_q[v] == IDLE) begin
                    if (!tx_hdr)
                        err_tx_d = 1'b1;
                    else if (!tx_tail)
                        pkt_d[v] = IN_PKT;
                end else begin
                    if (tx_hdr)
                        err_tx_d = 1'b1;
                    if (tx_tail)
                        pkt_d[v] = IDLE;
                end
            end
        end
    end

    // ---------------- ejection ----------------
    logic [V-1:0]    vc_field;
    logic            vc_ok;
    logic [V-1:0]    nonempty;
    logic [V-1:0]    full;
    logic [Vw-1:0]   arb_vc;
    logic            arb_found;
    logic [Vw-1:0]   rx_sel;
    logic            pop;
    logic [V-1:0]    pop_vec;
    logic [V-1:0]    wr_vec;
    logic [V-1:0]    wr_ok;
    logic [EW-1:0]   head;

    assign vc_field = flit_in[Fpay+V-1:Fpay];
    assign vc_ok    = $onehot(vc_field);

    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int v = 0; v < V; v++) begin
            nonempty[v] = (cnt_q[v] != '0);
            full[v]     = (cnt_q[v] == CW'(B));
        end
    end

    always_comb begin
        arb_vc    = rr_q;
        arb_found = 1'b0;
        for (int i = 0; i < V; i++) begin
            if (!arb_found && nonempty[(int'(rr_q) + i) % V]) begin
                arb_found = 1'b1;
                arb_vc    = Vw'((int'(rr_q) + i) % V);
            end
        end
    end

    // A presented but unaccepted flit stays put even if a higher-priority VC fills.
    assign rx_sel   = lock_q ? lock_vc_q : arb_vc;
    assign rx_valid = |nonempty;
    assign pop      = rx_valid & rx_ready;
    assign head     = mem_q[rx_sel][rd_ptr_q[rx_sel]];
    assign rx_hdr   = head[EW-1];
    assign rx_tail  = head[EW-2];
    assign rx_data  = head[Fpay-1:0];
    assign rx_vc    = rx_sel;

    always_comb begin
        pop_vec = '0;
        wr_vec  = '0;
        wr_ok   = '0;
        for (int v = 0; v < V; v++) begin
            pop_vec[v]  = pop && (rx_sel == Vw'(v));
            wr_vec[v]   = flit_in_wr && vc_ok && vc_field[v];
            // A pop frees the slot in the same edge, so a full FIFO can still take a write.
            wr_ok[v]    = wr_vec[v] && (!full[v] || pop_vec[v]);
            rd_ptr_d[v] = pop_vec[v] ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
            wr_ptr_d[v] = wr_ok[v]   ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
            cnt_d[v]    = cnt_q[v];
            if (wr_ok[v] && !pop_vec[v])
                cnt_d[v] = cnt_q[v] + CW'(1);
            else if (pop_vec[v] && !wr_ok[v])
                cnt_d[v] = cnt_q[v] - CW'(1);
        end
        err_rx_d     = err_q[2] | (flit_in_wr & ~vc_ok) | (|(wr_vec & ~wr_ok));
        credit_out_d = pop_vec;
        rr_d         = pop ? vc_inc(rx_sel) : rr_q;
        lock_d       = rx_valid & ~rx_ready;
        lock_vc_d    = rx_sel;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                credit_q[v] <= CW'(B);
                pkt_q[v]    <= IDLE;
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            flit_out_q    <= '0;
            flit_out_wr_q <= 1'b0;
            credit_out_q  <= '0;
            err_q         <= '0;
            rr_q          <= '0;
            lock_q        <= 1'b0;
            lock_vc_q     <= '0;
        end else begin
            for (int v = 0; v < V; v++) begin
                credit_q[v] <= credit_d[v];
                pkt_q[v]    <= pkt_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
            if (accept)
                flit_out_q <= {tx_hdr, tx_tail, tx_sel, tx_data};
            flit_out_wr_q <= accept;
            credit_out_q  <= credit_out_d;
            err_q         <= {err_rx_d, err_cr_d, err_tx_d};
            rr_q          <= rr_d;
            lock_q        <= lock_d;
            lock_vc_q     <= lock_vc_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < V; v++) begin
            if (wr_ok[v])
                mem_q[v][wr_ptr_q[v]] <= {flit_in[Fw-1], flit_in[Fw-2], flit_in[Fpay-1:0]};
        end
    end

    assign flit_out    = flit_out_q;
    assign flit_out_wr = flit_out_wr_q;
    assign credit_out  = credit_out_q;
    assign err         = err_q;

endmodule

// File: tb/tb_noc_endpoint_ni.sv
// Randomised and directed bench for noc_endpoint_ni against a queue-based reference model.
module tb_noc_endpoint_ni;

    localparam int V    = 4;
    localparam int B    = 4;
    localparam int Fpay = 32;
    localparam int Fw   = 2 + V + Fpay;
    localparam int Vw   = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tx_valid;
    logic            tx_ready;
    logic            tx_hdr;
    logic            tx_tail;
    logic [Vw-1:0]   tx_vc;
    logic [Fpay-1:0] tx_data;
    logic [Fw-1:0]   flit_out;
    logic            flit_out_wr;
    logic [V-1:0]    credit_in;
    logic [Fw-1:0]   flit_in;
    logic            flit_in_wr;
    logic [V-1:0]    credit_out;
    logic            rx_valid;
    logic            rx_ready;
    logic            rx_hdr;
    logic            rx_tail;
    logic [Vw-1:0]   rx_vc;
    logic [Fpay-1:0] rx_data;
    logic [2:0]      err;

    always #5 clk = ~clk;

    noc_endpoint_ni #(.V(V), .B(B), .Fpay(Fpay)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_hdr(tx_hdr), .tx_tail(tx_tail),
        .tx_vc(tx_vc), .tx_data(tx_data), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
        .credit_in(credit_in), .flit_in(flit_in), .flit_in_wr(flit_in_wr),
        .credit_out(credit_out), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_hdr(rx_hdr), .rx_tail(rx_tail), .rx_vc(rx_vc), .rx_data(rx_data), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int              m_cred [V];
    bit              m_inpkt [V];
    logic [Fpay+1:0] m_q [V][$];
    int              m_rr;
    bit              m_held;
    int              m_held_vc;
    logic            m_fo_wr;
    logic [Fw-1:0]   m_fo;
    logic [V-1:0]    m_cout;
    logic [2:0]      m_err;
    bit              m_last_acc;
    int              m_last_vc;
    int              outst [V];

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_cred[v] = B; m_inpkt[v] = 0; m_q[v].delete(); outst[v] = 0;
        end
        m_rr = 0; m_held = 0; m_held_vc = 0;
        m_fo_wr = 0; m_fo = '0; m_cout = '0; m_err = '0; m_last_acc = 0; m_last_vc = 0;
    endtask

    function automatic int m_shown();
        if (m_held) return m_held_vc;
        for (int i = 0; i < V; i++)
            if (m_q[(m_rr + i) % V].size() > 0) return (m_rr + i) % V;
        return -1;
    endfunction

    task automatic check_outputs();
        int sh;
        logic [Fpay+1:0] e;
        chk("tx_ready", tx_ready, m_cred[int'(tx_vc)] > 0);
        chk("flit_out_wr", flit_out_wr, m_fo_wr);
        chk("flit_out", flit_out, m_fo);
        chk("credit_out", credit_out, m_cout);
        chk("err", err, m_err);
        sh = m_shown();
        chk("rx_valid", rx_valid, sh >= 0);
        if (sh >= 0) begin
            e = m_q[sh][0];
            chk("rx_vc", rx_vc, sh);
            chk("rx_hdr", rx_hdr, e[Fpay+1]);
            chk("rx_tail", rx_tail, e[Fpay]);
            chk("rx_data", rx_data, e[Fpay-1:0]);
        end
    endtask

    task automatic model_step();
        int sh;
        bit acc;
        int tv;
        sh = m_shown();
        tv = int'(tx_vc);
        acc = tx_valid && (m_cred[tv] > 0);
        for (int v = 0; v < V; v++) begin
            int c;
            c = m_cred[v] + int'(credit_in[v]) - ((acc && tv == v) ? 1 : 0);
            if (c > B) begin c = B; m_err[1] = 1'b1; end
            m_cred[v] = c;
        end
        m_last_acc = acc; m_last_vc = tv;
        m_fo_wr = acc;
        if (acc) begin
            if ((!m_inpkt[tv] && !tx_hdr) || (m_inpkt[tv] && tx_hdr)) m_err[0] = 1'b1;
            if (tx_tail) m_inpkt[tv] = 0;
            else if (tx_hdr) m_inpkt[tv] = 1;
            m_fo = {tx_hdr, tx_tail, 4'b0001 << tv, tx_data};
        end
        if (sh >= 0 && rx_ready) begin
            void'(m_q[sh].pop_front());
            m_rr = (sh + 1) % V;
            m_cout = 4'b0001 << sh;
            m_held = 0;
        end else begin
            m_cout = '0;
            m_held = (sh >= 0);
            m_held_vc = sh;
        end
        if (flit_in_wr) begin
            logic [V-1:0] f;
            f = flit_in[Fpay+V-1:Fpay];
            if ($countones(f) != 1) m_err[2] = 1'b1;
            else begin
                int w;
                w = 0;
                for (int v = 0; v < V; v++) if (f[v]) w = v;
                if (m_q[w].size() < B) m_q[w].push_back({flit_in[Fw-1], flit_in[Fw-2], flit_in[Fpay-1:0]});
                else m_err[2] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_valid = 0; tx_hdr = 0; tx_tail = 0; credit_in = '0; flit_in_wr = 0;
    endtask

    function automatic logic [Fw-1:0] mkf(input bit h, input bit t, input logic [V-1:0] oh,
                                          input logic [Fpay-1:0] d);
        return {h, t, oh, d};
    endfunction

    task automatic tx(input bit h, input bit t, input int vc);
        tx_valid = 1; tx_hdr = h; tx_tail = t; tx_vc = Vw'(vc); tx_data = $urandom;
        cycle();
        tx_valid = 0;
    endtask

    task automatic rxw(input int vc);
        flit_in_wr = 1;
        flit_in = mkf($urandom_range(0, 1), $urandom_range(0, 1), 4'b0001 << vc, $urandom);
        cycle();
        flit_in_wr = 0;
    endtask

    // Asynchronous reset, asserted away from any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_credit_out", credit_out, '0);
        chk("rst_err", err, '0);
        chk("rst_flit_out_wr", flit_out_wr, 1'b0);
        chk("rst_flit_out", flit_out, '0);
        for (int v = 0; v < V; v++) begin
            tx_vc = Vw'(v);
            #1;
            chk("rst_tx_ready", tx_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        idle();
        tx_vc = '0; tx_data = '0; flit_in = '0; rx_ready = 0;
        do_reset();
        repeat (2) cycle();

        // Credit exhaustion on VC2, with VC0 unaffected, then one returned credit.
        for (int i = 0; i < 4; i++) tx(1, 1, 2);
        tx_vc = 2; cycle();
        chk("vc2_exhausted", tx_ready, 1'b0);
        tx_vc = 0; cycle();
        tx_vc = 2; credit_in = 4'b0100; cycle();
        credit_in = '0; cycle();

        // Same-cycle credit and accept on VC1, then overflow credit on VC3.
        for (int i = 0; i < 3; i++) tx(1, 1, 1);
        credit_in = 4'b0010; tx(1, 1, 1);
        credit_in = '0;
        tx_vc = 1; cycle();
        tx(1, 1, 1);
        tx_vc = 1; cycle();
        credit_in = 4'b1000; cycle();
        credit_in = '0; cycle();
        chk("err_credit_ovf", err, 3'b010);

        // Packet framing on VC0, then a body flit in IDLE.
        do_reset();
        tx(1, 0, 0); tx(0, 0, 0); tx(0, 1, 0);
        cycle();
        chk("err_clean_pkt", err, 3'b000);
        tx(0, 0, 0);
        cycle();

        // Round-robin ejection and credit return.
        do_reset();
        rx_ready = 1;
        rxw(0); rxw(1); rxw(3);
        repeat (4) cycle();

        // FIFO overflow on VC2, then drain.
        rx_ready = 0;
        for (int i = 0; i < 5; i++) rxw(2);
        cycle();
        chk("err_fifo_ovf", err[2], 1'b1);
        rx_ready = 1;
        repeat (6) cycle();

        // Reset while holding buffered flits and mid-packet on TX.
        do_reset();
        tx(1, 0, 0);
        rx_ready = 0;
        rxw(1); rxw(1); rxw(1);
        rx_ready = 1;
        cycle();
        do_reset();
        repeat (4) cycle();

        // Randomised traffic with a credit-returning router model.
        for (int n = 0; n < 3000; n++) begin
            logic [V-1:0] ci;
            logic [V-1:0] f;
            tx_valid = ($urandom_range(0, 1) == 1);
            tx_vc    = Vw'($urandom_range(0, V - 1));
            tx_hdr   = ($urandom_range(0, 2) == 0);
            tx_tail  = ($urandom_range(0, 2) == 0);
            tx_data  = $urandom;
            ci = '0;
            for (int v = 0; v < V; v++)
                if (outst[v] > 0 && $urandom_range(0, 2) == 0) begin ci[v] = 1'b1; outst[v]--; end
            if ($urandom_range(0, 299) == 0) ci[$urandom_range(0, V - 1)] = 1'b1;
            credit_in = ci;
            flit_in_wr = ($urandom_range(0, 2) == 0);
            f = 4'b0001 << $urandom_range(0, V - 1);
            if ($urandom_range(0, 31) == 0) f = 4'($urandom_range(0, 15));
            flit_in  = mkf($urandom_range(0, 1), $urandom_range(0, 1), f, $urandom);
            rx_ready = ($urandom_range(0, 1) == 1);
            cycle();
            if (m_last_acc) outst[m_last_vc]++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_endpoint_ni.md
Name: noc_endpoint_ni

Overview:
- Single-endpoint network interface on one router local port of the NoC.
- Injection path: accepts flits from a core-side valid/ready interface, packs them into the NoC flit format, and enforces credit-based flow control per VC.
- Ejection path: buffers flits from the router in per-VC FIFOs, delivers them to the core round-robin, and returns one credit per consumed flit.

Parameters:
- V, 4, virtual channels per port.
- B, 4, flit buffer depth per VC; also the initial credits per VC.
- Fpay, 32, payload width in bits.
- Fw, 2+V+Fpay, flit width (derived; do not override).
- Vw, log2(V) (min 1), binary VC index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  core flit valid.
- tx_ready  out  1  flit accepted this cycle when tx_valid is also high.
- tx_hdr  in  1  header flag.
- tx_tail  in  1  tail flag.
- tx_vc  in  Vw  target VC, binary.
- tx_data  in  Fpay  payload.
- flit_out  out  Fw  flit to the router.
- flit_out_wr  out  1  flit_out valid.
- credit_in  in  V  credit return from the router, one pulse per flit.
- flit_in  in  Fw  flit from the router.
- flit_in_wr  in  1  flit_in valid.
- credit_out  out  V  credit to the router, one pulse per popped flit.
- rx_valid  out  1  ejected flit available.
- rx_ready  in  1  core consumes the flit.
- rx_hdr, rx_tail  out  1 each  flags of the head flit.
- rx_vc  out  Vw  VC of the head flit.
- rx_data  out  Fpay  payload of the head flit.
- err  out  3  sticky errors: [0] tx protocol, [1] credit overflow, [2] rx FIFO overflow.

Behaviour:
- Flit layout:
  - bit Fw-1 = header flag; bit Fw-2 = tail flag.
  - [Fpay+V-1:Fpay] = one-hot VC.
  - [Fpay-1:0] = payload.
  - A single-flit packet has both flags set.
- Reset (reset low, asynchronous):
  - flit_out=0, flit_out_wr=0, credit_out=0, err=0, rx_valid=0.
  - All credit counters=B; all FIFOs empty; RR pointer=0; all tx VC states IDLE.
- TX credit counters:
  - One counter per VC, width log2(B+1).
  - tx_ready = (credit[tx_vc] != 0); combinational, and independent of tx_valid.
  - Accept at edge N: flit_out and flit_out_wr are registered and visible in cycle N+1.
  - flit_out_wr is low in every cycle without an accept. flit_out holds its last value when idle.
- Credit arithmetic, per VC, every cycle:
  - credit_in only: +1.
  - Accept only: -1.
  - Both in the same cycle: unchanged.
  - credit_in while the counter is B and no accept: counter holds at B and err[1] is set.
  - A credit arriving in cycle N is usable for tx_ready in N+1, not in N.
- TX packet FSM, per VC, states IDLE and IN_PKT:
  - IDLE, accept with hdr&!tail: go to IN_PKT.
  - IDLE, accept with hdr&tail: stay IDLE.
  - IN_PKT, accept with tail: go to IDLE.
  - Protocol violation sets err[0]; the flit is still transmitted. Violations:
    - accept without hdr in IDLE;
    - accept with hdr in IN_PKT.
- RX FIFOs:
  - flit_in_wr writes flit_in into the FIFO selected by its one-hot VC field, at the edge.
  - A write to a full FIFO is dropped and sets err[2].
  - A zero or multi-hot VC field drops the flit and sets err[2].
- RX output:
  - Show-ahead: rx_* reflects the head of the VC chosen by the round-robin arbiter among non-empty FIFOs, starting at the RR pointer.
  - rx_valid is high when any FIFO is non-empty.
  - A flit written at edge N can appear on rx_* in cycle N+1.
- RX pop:
  - Pop occurs on rx_valid & rx_ready.
  - On pop from VC v, the RR pointer becomes (v+1) mod V.
  - credit_out[v] pulses high for exactly one cycle, in the cycle after the pop (registered).
  - A simultaneous write to and pop from the same FIFO is legal, including when the FIFO is full; occupancy is unchanged.
- Outputs stay stable while rx_valid & !rx_ready (same VC, same flit) unless reset occurs.
- Reset mid-packet: all state is discarded immediately and credits return to B. There is no partial-packet recovery.

Test Plan:
- V=4,B=4: after reset, 4 back-to-back accepts on VC2 with no credit_in → 4 flit_out_wr pulses, then tx_ready=0 for VC2 while VC0 is still ready; one credit_in[2] pulse → tx_ready=1 one cycle later.
- Credit and accept on VC1 in the same cycle with credit=1 → counter stays 1; credit_in[3] at full credit → err=3'b010, counter 4.
- TX packet hdr, body, tail on VC0 → flit_out = {1,0,4'b0001,D0}, {0,0,0001,D1}, {0,1,0001,D2}; err=0. Body flit sent in IDLE → err[0]=1.
- RX: write one flit each to VC0, VC1, VC3 with rx_ready=1 → rx_vc order 0,1,3; credit_out pulses 0001, 0010, 1000, each one cycle after its pop.
- RX: 5 writes to VC2 with rx_ready=0 → 5th dropped, err[2]=1; then 4 pops → 4 credit_out[2] pulses.
- Reset asserted mid-packet with 2 flits buffered → rx_valid=0 and credit_out=0 immediately, no credit pulses for the discarded flits; tx_ready=1 on all VCs after release.
